// File: rtl/seq_pattern_pkg.sv
// Shared types and default constants for the serial pattern transmitter.
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int                         DEFAULT_SEQ_LEN = 4;
    localparam logic [DEFAULT_SEQ_LEN-1:0] DEFAULT_SEQ     = 4'b1011;
    localparam int                         DEFAULT_GAP_CYC = 2;
    localparam int                         DEFAULT_REP_W   = 4;

endpackage

// File: rtl/seq_bit_shifter.sv
// Walks a fixed pattern MSB-first; next_bit is the bit that will be on the line
// after the coming clock edge, so the caller can register it directly.
module seq_bit_shifter
    import seq_pattern_pkg::*;
#(
    parameter int                 SEQ_LEN = DEFAULT_SEQ_LEN,
    parameter logic [SEQ_LEN-1:0] SEQ     = DEFAULT_SEQ
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic advance,
    output logic next_bit,
    output logic last_bit
);

    localparam int                 IDX_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(SEQ_LEN - 1);

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_d;

    // Advancing past bit 0 wraps straight to the MSB so back-to-back repetitions need no bubble.
    always_comb begin
        idx_d = idx;
        if (load) begin
            idx_d = LAST_IDX;
        end else if (advance) begin
            if (idx == '0) begin
                idx_d = LAST_IDX;
            end else begin
                idx_d = idx - IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else begin
            idx <= idx_d;
        end
    end

    assign next_bit = SEQ[idx_d];
    assign last_bit = (idx == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends SEQ a requested number of times with an idle
// gap between repetitions, handshaking through start/busy/done.
module seq_pattern_gen
    import seq_pattern_pkg::*;
#(
    parameter int                 SEQ_LEN = DEFAULT_SEQ_LEN,
    parameter logic [SEQ_LEN-1:0] SEQ     = DEFAULT_SEQ,
    parameter int                 GAP_CYC = DEFAULT_GAP_CYC,
    parameter int                 REP_W   = DEFAULT_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             o,
    output logic             o_valid,
    output logic             busy,
    output logic             done
);

    localparam int               GAP_W    = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);

    state_t             state;
    state_t             state_d;
    logic [REP_W-1:0]   rep_cnt;
    logic [REP_W-1:0]   rep_d;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_d;
    logic               load;
    logic               advance;
    logic               next_bit;
    logic               last_bit;

    seq_bit_shifter #(
        .SEQ_LEN (SEQ_LEN),
        .SEQ     (SEQ)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .advance  (advance),
        .next_bit (next_bit),
        .last_bit (last_bit)
    );

    always_comb begin
        state_d = state;
        rep_d   = rep_cnt;
        gap_d   = gap_cnt;
        load    = 1'b0;
        advance = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (reps != '0) begin
                        rep_d   = reps;
                        load    = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SEND: begin
                advance = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    rep_d   = '0;
                end else if (last_bit) begin
                    if (rep_cnt > REP_W'(1)) begin
                        rep_d = rep_cnt - REP_W'(1);
                        // Without a gap we stay in SEND; the shifter has already wrapped to the MSB.
                        if (GAP_CYC > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end else begin
                        state_d = DONE;
                        rep_d   = '0;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    rep_d   = '0;
                    gap_d   = '0;
                end else if (gap_cnt <= GAP_W'(1)) begin
                    state_d = SEND;
                    load    = 1'b1;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_cnt - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rep_cnt <= '0;
            gap_cnt <= '0;
            o       <= 1'b0;
            o_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            rep_cnt <= rep_d;
            gap_cnt <= gap_d;
            o       <= (state_d == SEND) && next_bit;
            o_valid <= (state_d == SEND);
            busy    <= (state_d == SEND) || (state_d == GAP);
            done    <= (state_d == DONE);
        end
    end

endmodule
